// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the registered priority encoder.
// Optional rotating priority is enabled by defining PRIO_ENC_ROUND_ROBIN_EN.
package prio_enc_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // Index width for n request lines, never below one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational N->W priority encoder. The search starts at bit 'base' and descends,
// wrapping from 0 to N-1, so bit base+1 (mod N) has the lowest priority.
module prio_enc_core
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] base,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        // Walk from lowest to highest priority so the highest-priority hit is written last.
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(base) - i;
            if (j < 0) j = j + N;
            if (req[j]) begin
                idx = j[W-1:0];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_encoder_seq.sv
// Registered priority encoder: sticky pending requests drained one index per valid/ready accept.
// Define PRIO_ENC_ROUND_ROBIN_EN for rotating priority; otherwise bit N-1 always wins.
module priority_encoder_seq
    import prio_enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = idx_w(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_in,
    output logic [W-1:0] out_idx,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [N-1:0] pending
);

    state_t       state;
    logic         accept;
    logic [N-1:0] grant_oh;
    logic [N-1:0] nxt_pend;
    logic [W-1:0] base;
    logic [W-1:0] enc_idx;
    logic         enc_any;

    assign accept   = out_vld & out_rdy;
    assign grant_oh = accept ? (N'(1) << out_idx) : '0;
    // A bit cleared by this accept and set again by req_in stays pending.
    assign nxt_pend = (pending & ~grant_oh) | req_in;

`ifdef PRIO_ENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr;
    logic [W-1:0] acc_base;

    // ptr holds the first bit searched; after accepting k the search resumes at k-1.
    assign acc_base = (out_idx == '0) ? W'(N - 1) : out_idx - W'(1);
    assign base     = accept ? acc_base : ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= W'(N - 1);
        end else if (accept) begin
            ptr <= acc_base;
        end
    end
`else
    assign base = W'(N - 1);
`endif

    prio_enc_core #(
        .N (N)
    ) u_core (
        .req  (nxt_pend),
        .base (base),
        .idx  (enc_idx),
        .any  (enc_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            state   <= IDLE;
            out_vld <= 1'b0;
            out_idx <= '0;
        end else begin
            pending <= nxt_pend;
            case (state)
                IDLE: begin
                    if (enc_any) begin
                        out_idx <= enc_idx;
                        out_vld <= 1'b1;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    // No preemption: the presented index only moves on an accept.
                    if (accept) begin
                        if (enc_any) begin
                            out_idx <= enc_idx;
                        end else begin
                            out_vld <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    out_vld <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Directed self-checking bench for priority_encoder_seq with N=8.
// Expectations follow PRIO_ENC_ROUND_ROBIN_EN when it is defined for the build.
module tb_priority_encoder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_in;
    logic [2:0] out_idx;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] pending;

    int checks = 0;
    int errors = 0;

    priority_encoder_seq #(.N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (req_in),
        .out_idx (out_idx),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .pending (pending)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset holds everything clear even with all requests high
        rst_n   = 1'b0;
        req_in  = 8'hFF;
        out_rdy = 1'b0;
        #3;
        chk("rst_vld", 32'(out_vld), 32'd0);
        chk("rst_idx", 32'(out_idx), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        tick();
        chk("rst_vld_edge", 32'(out_vld), 32'd0);
        chk("rst_pend_edge", 32'(pending), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_vld", 32'(out_vld), 32'd1);
        chk("rel_idx", 32'(out_idx), 32'd7);
        chk("rel_pend", 32'(pending), 32'hFF);
        req_in  = 8'h00;
        out_rdy = 1'b1;
        for (int k = 6; k >= 0; k--) begin
            tick();
            chk("drain_idx", 32'(out_idx), 32'(k));
            chk("drain_vld", 32'(out_vld), 32'd1);
        end
        tick();
        chk("drain_done_vld", 32'(out_vld), 32'd0);
        chk("drain_done_pend", 32'(pending), 32'd0);

        // 2: fixed priority pulse 0010_0100 -> 5 then 2
        req_in = 8'b0010_0100;
        tick();
        chk("fp_idx5", 32'(out_idx), 32'd5);
        chk("fp_vld5", 32'(out_vld), 32'd1);
        chk("fp_pend", 32'(pending), 32'h24);
        req_in = 8'h00;
        tick();
        chk("fp_idx2", 32'(out_idx), 32'd2);
        chk("fp_pend2", 32'(pending), 32'h04);
        tick();
        chk("fp_vld_end", 32'(out_vld), 32'd0);
        chk("fp_pend_end", 32'(pending), 32'd0);

        // 3: presented index holds against a higher-priority arrival
        out_rdy = 1'b0;
        req_in  = 8'h01;
        tick();
        chk("hold_idx0", 32'(out_idx), 32'd0);
        req_in = 8'h80;
        tick();
        chk("hold_idx_keep", 32'(out_idx), 32'd0);
        chk("hold_pend", 32'(pending), 32'h81);
        req_in = 8'h00;
        tick();
        chk("hold_idx_keep2", 32'(out_idx), 32'd0);
        chk("hold_vld", 32'(out_vld), 32'd1);
        out_rdy = 1'b1;
        tick();
        chk("hold_idx7", 32'(out_idx), 32'd7);
        chk("hold_pend_after", 32'(pending), 32'h80);
        tick();
        chk("hold_vld_end", 32'(out_vld), 32'd0);

        // 4: clear and set of the same bit in one cycle keeps it pending
        out_rdy = 1'b0;
        req_in  = 8'h08;
        tick();
        chk("col_idx", 32'(out_idx), 32'd3);
        out_rdy = 1'b1;
        tick();
        chk("col_pend", 32'(pending), 32'h08);
        chk("col_idx_again", 32'(out_idx), 32'd3);
        chk("col_vld", 32'(out_vld), 32'd1);
        req_in = 8'h00;
        tick();
        chk("col_vld_end", 32'(out_vld), 32'd0);
        chk("col_pend_end", 32'(pending), 32'd0);

        // 5: asynchronous reset while presenting, nothing replayed afterwards
        out_rdy = 1'b0;
        req_in  = 8'h40;
        tick();
        chk("ar_idx6", 32'(out_idx), 32'd6);
        req_in = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld_async", 32'(out_vld), 32'd0);
        chk("ar_idx_async", 32'(out_idx), 32'd0);
        chk("ar_pend_async", 32'(pending), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ar_no_replay_vld", 32'(out_vld), 32'd0);
        chk("ar_no_replay_pend", 32'(pending), 32'd0);

        // 6: held 8'h81 with out_rdy high
        out_rdy = 1'b1;
        req_in  = 8'h81;
        tick();
        chk("rr_first", 32'(out_idx), 32'd7);
        for (int k = 1; k < 5; k++) begin
            tick();
`ifdef PRIO_ENC_ROUND_ROBIN_EN
            chk("rr_seq", 32'(out_idx), (k % 2 == 1) ? 32'd0 : 32'd7);
`else
            chk("fixed_seq", 32'(out_idx), 32'd7);
`endif
            chk("seq_vld", 32'(out_vld), 32'd1);
        end
        req_in = 8'h00;
        for (int k = 0; k < 4; k++) tick();
        chk("final_vld", 32'(out_vld), 32'd0);
        chk("final_pend", 32'(pending), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
